// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and access-legality decode for the load/store unit.
package lsu_pkg;

  // Request life cycle: IDLE -> (RD -> WAIT) -> (WR) -> RESP -> IDLE
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True when the funct3 is defined for the direction and the address is
  // naturally aligned for the access size. Unsigned forms exist for loads only.
  function automatic logic is_legal_access(input logic       we,
                                           input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = !addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = !we;
      F3_HU:   ok = !we && !addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a RAM word and sign- or
// zero-extends it according to the load funct3.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection and extension
  always_comb begin
    byte_lane = word[8*addr_lo +: 8];
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    result    = 32'd0;
    case (funct3)
      F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    result = {{16{half_lane[15]}}, half_lane};
      F3_W:    result = word;
      F3_BU:   result = {24'd0, byte_lane};
      F3_HU:   result = {16'd0, half_lane};
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-wide RAM with 1-cycle registered
// read and no byte enables. Sub-word stores are read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  ram_ren,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  localparam int AW = ADDR_WIDTH + 2;

  state_t          state_reg, state_next;
  logic            we_reg;
  logic [2:0]      funct3_reg;
  logic [AW-1:0]   addr_reg;
  logic [31:0]     wdata_reg;
  logic            err_reg;
  logic [31:0]     merged_reg;
  logic [31:0]     rdata_reg;

  logic            accept;
  logic            req_err;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]     load_result;
  logic [31:0]     merge_word;

  // Bits above the RAM window alias and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW];

  assign accept   = req_valid && req_ready;
  assign req_err  = !is_legal_access(req_we, req_funct3, req_addr[1:0]);
  assign word_idx = addr_reg[AW-1:2];

  load_extend u_load_extend (
    .word    (ram_rdata),
    .addr_lo (addr_reg[1:0]),
    .funct3  (funct3_reg),
    .result  (load_result)
  );

  // Store merge: each byte lane takes store data when it is covered by the
  // SB/SH access, otherwise keeps the word just read from RAM.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      logic       lane_hit;
      logic [7:0] lane_data;
      assign lane_hit  = ((funct3_reg == F3_B) && (addr_reg[1:0] == gi[1:0])) ||
                         ((funct3_reg == F3_H) && (addr_reg[1] == gi[1]));
      assign lane_data = ((funct3_reg == F3_H) && gi[0]) ? wdata_reg[15:8]
                                                         : wdata_reg[7:0];
      assign merge_word[8*gi +: 8] = lane_hit ? lane_data : ram_rdata[8*gi +: 8];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (req_err)                                state_next = RESP;
          else if (req_we && (req_funct3 == F3_W))    state_next = WR;
          else                                        state_next = RD;
        end
      end
      RD:   state_next = WAIT;
      WAIT: state_next = we_reg ? WR : RESP;
      WR:   state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg     <= 1'b0;
      funct3_reg <= 3'd0;
      addr_reg   <= '0;
      wdata_reg  <= 32'd0;
      err_reg    <= 1'b0;
    end else if (accept) begin
      we_reg     <= req_we;
      funct3_reg <= req_funct3;
      addr_reg   <= req_addr[AW-1:0];
      wdata_reg  <= req_wdata;
      err_reg    <= req_err;
    end
  end

  // RAM read capture: load result or merged store word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      merged_reg <= 32'd0;
      rdata_reg  <= 32'd0;
    end else begin
      if (state_reg == WAIT) begin
        if (we_reg) merged_reg <= merge_word;
        else        rdata_reg  <= load_result;
      end
      // Store and error responses report zero data.
      if ((state_reg == WR) || ((state_reg == IDLE) && (state_next == RESP)))
        rdata_reg <= 32'd0;
    end
  end

  // Combinational outputs, zero outside their owning state
  always_comb begin
    req_ready = (state_reg == IDLE) && !rst;
    rsp_valid = (state_reg == RESP);
    rsp_err   = (state_reg == RESP) && err_reg;
    rsp_rdata = rdata_reg;
    ram_ren   = 1'b0;
    ram_raddr = '0;
    ram_wen   = 1'b0;
    ram_waddr = '0;
    ram_wdata = 32'd0;
    if (state_reg == RD) begin
      ram_ren   = 1'b1;
      ram_raddr = word_idx;
    end
    if (state_reg == WR) begin
      ram_wen   = 1'b1;
      ram_waddr = word_idx;
      ram_wdata = (funct3_reg == F3_W) ? wdata_reg : merged_reg;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural single-clock RAM.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MEM_DEPTH = 256;
  localparam int AWID = $clog2(MEM_DEPTH);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [2:0]      req_funct3 = 3'd0;
  logic [31:0]     req_addr = 32'd0;
  logic [31:0]     req_wdata = 32'd0;
  logic            rsp_valid;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic            ram_ren, ram_wen;
  logic [AWID-1:0] ram_raddr, ram_waddr;
  logic [31:0]     ram_wdata;
  logic [31:0]     ram_rdata = 32'd0;

  logic [31:0] mem [MEM_DEPTH];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_raddr(ram_raddr),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM model: registered read, separate write port
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request from IDLE to its response; called at posedge+1 in IDLE.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_cyc, input logic exp_err, input logic [31:0] exp_rdata,
                      input int exp_ren, input int exp_wen);
    int cyc, ren_cnt, wen_cnt, both;
    logic [AWID-1:0] waddr;
    cyc = 0; ren_cnt = 0; wen_cnt = 0; both = 0; waddr = '0;
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (ram_ren) ren_cnt++;
      if (ram_wen) begin wen_cnt++; waddr = ram_waddr; end
      if (ram_ren && ram_wen) both++;
      if (rsp_valid) begin cyc = c; break; end
      @(posedge clk); #1;
    end
    check({tag, ".rsp_cycle"}, cyc, exp_cyc);
    check({tag, ".rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    check({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
    check({tag, ".ren_cnt"}, ren_cnt, exp_ren);
    check({tag, ".wen_cnt"}, wen_cnt, exp_wen);
    check({tag, ".rd_wr_overlap"}, both, 0);
    if (exp_wen != 0) check({tag, ".waddr"}, {24'd0, waddr}, {22'd0, addr[AWID+1:2]});
    $display("[TB] %s we=%0b f3=%03b addr=0x%08h wdata=0x%08h -> cyc=%0d err=%0b rdata=0x%08h",
             tag, we, f3, addr, wdata, cyc, rsp_err, rsp_rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    int wen_seen;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = 32'd0;

    // Reset state
    @(posedge clk); #1;
    check("rst.req_ready", {31'd0, req_ready}, 32'd0);
    check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst.rsp_err",   {31'd0, rsp_err},   32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.ram_ren",   {31'd0, ram_ren},   32'd0);
    check("rst.ram_wen",   {31'd0, ram_wen},   32'd0);
    check("rst.ram_wdata", ram_wdata, 32'd0);
    check("rst.ram_addr",  {24'd0, ram_raddr | ram_waddr}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst.release_ready", {31'd0, req_ready}, 32'd1);

    // Word round trip
    xact("sw_dead",  1'b1, F3_W, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0,        0, 1);
    xact("lw_dead",  1'b0, F3_W, 32'h10, 32'h0,        3, 1'b0, 32'hDEADBEEF, 1, 0);

    // Byte store and loads
    xact("sw_base1", 1'b1, F3_W,  32'h10, 32'h11223344, 2, 1'b0, 32'h0,        0, 1);
    xact("sb_aa",    1'b1, F3_B,  32'h11, 32'h000000AA, 4, 1'b0, 32'h0,        1, 1);
    xact("lw_sb",    1'b0, F3_W,  32'h10, 32'h0,        3, 1'b0, 32'h1122AA44, 1, 0);
    xact("lb_11",    1'b0, F3_B,  32'h11, 32'h0,        3, 1'b0, 32'hFFFFFFAA, 1, 0);
    xact("lbu_11",   1'b0, F3_BU, 32'h11, 32'h0,        3, 1'b0, 32'h000000AA, 1, 0);
    xact("lb_13",    1'b0, F3_B,  32'h13, 32'h0,        3, 1'b0, 32'h00000011, 1, 0);

    // Half store and loads
    xact("sw_base2", 1'b1, F3_W,  32'h10, 32'h11223344, 2, 1'b0, 32'h0,        0, 1);
    xact("sh_8001",  1'b1, F3_H,  32'h12, 32'h00008001, 4, 1'b0, 32'h0,        1, 1);
    xact("lw_sh",    1'b0, F3_W,  32'h10, 32'h0,        3, 1'b0, 32'h80013344, 1, 0);
    xact("lh_12",    1'b0, F3_H,  32'h12, 32'h0,        3, 1'b0, 32'hFFFF8001, 1, 0);
    xact("lhu_12",   1'b0, F3_HU, 32'h12, 32'h0,        3, 1'b0, 32'h00008001, 1, 0);
    xact("lh_10",    1'b0, F3_H,  32'h10, 32'h0,        3, 1'b0, 32'h00003344, 1, 0);

    // Errors: no RAM traffic, response in cycle 1, zero data
    xact("err_lw13", 1'b0, F3_W,   32'h13, 32'h0,    1, 1'b1, 32'h0, 0, 0);
    xact("err_f011", 1'b0, 3'b011, 32'h10, 32'h0,    1, 1'b1, 32'h0, 0, 0);
    xact("err_sh11", 1'b1, F3_H,   32'h11, 32'h1234, 1, 1'b1, 32'h0, 0, 0);
    xact("err_sbu",  1'b1, F3_BU,  32'h10, 32'h55,   1, 1'b1, 32'h0, 0, 0);

    // Reset pulsed during the WAIT state of an SB read-modify-write
    check("rmw.ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wen_seen = 0;
    if (ram_wen) wen_seen++;
    @(posedge clk); #1;
    if (ram_wen) wen_seen++;
    rst = 1'b1;
    #1;
    check("rmw.rst_ready", {31'd0, req_ready}, 32'd0);
    check("rmw.rst_ren",   {31'd0, ram_ren},   32'd0);
    #2;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (ram_wen) wen_seen++;
    end
    check("rmw.wen_seen", wen_seen, 0);
    check("rmw.idle_ready", {31'd0, req_ready}, 32'd1);
    $display("[TB] rmw_reset sb addr=0x10 reset in WAIT -> wen_seen=%0d", wen_seen);
    xact("lw_after_rst", 1'b0, F3_W, 32'h10, 32'h0, 3, 1'b0, 32'h80013344, 1, 0);

    // Address aliasing modulo 4*MEM_DEPTH bytes
    xact("sw_alias", 1'b1, F3_W, 32'h410, 32'hCAFEF00D, 2, 1'b0, 32'h0,        0, 1);
    xact("lw_alias", 1'b0, F3_W, 32'h10,  32'h0,        3, 1'b0, 32'hCAFEF00D, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
